// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the SimpleCPU datapath.
// Sequences FETCH / DECODE / EXEC / MEMRD / MEMWR / WB and a sticky FAULT state,
// and drives the datapath selects and enables from the current state.
// Optional feature: define CTRL_PERF_CNT_EN to build the cycleCount/instRetired
// performance counters; without it both ports read 0 and no counter flops exist.
// Memory handshake: memReq stays high until memReady is sampled high; the access
// completes in that same cycle. memReady while memReq is low is ignored.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        aluZero,
   input  logic        memReady,
   output logic        memReq,
   output logic        memWrite,
   output logic        iOrD,
   output logic        irWrite,
   output logic        pcWrite,
   output logic        pcSrc,
   output logic        regWrite,
   output logic        memToReg,
   output logic        aluSrcA,
   output logic [1:0]  aluSrcB,
   output logic [1:0]  aluOp,
   output logic        fault,
   output logic        retire,
   output logic [31:0] cycleCount,
   output logic [31:0] instRetired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEMRD  = 3'd3,
      S_MEMWR  = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd6
   } state_e;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ADDI   = 7'b0010011;
   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   // Last wait cycle that may still be rescued by memReady.
   localparam logic [7:0] TMO_LAST  = 8'(MEM_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] tmo_q, tmo_d;
   logic       wb_mem_q, wb_mem_d;

   logic is_rtype, is_addi, is_lw, is_sw, is_branch;
   logic br_funct_ok, op_legal, br_taken;
   logic req_s, wait_s, tmo_hit;

   // funct7b5 only steers the ALU decoder; the sequence never depends on it.
   logic unused_funct7b5;
   assign unused_funct7b5 = funct7b5;

   assign is_rtype    = (opcode == OP_RTYPE);
   assign is_addi     = (opcode == OP_ADDI);
   assign is_lw       = (opcode == OP_LW);
   assign is_sw       = (opcode == OP_SW);
   assign is_branch   = (opcode == OP_BRANCH);
   assign br_funct_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
   assign op_legal    = is_rtype || is_addi || is_lw || is_sw || (is_branch && br_funct_ok);
   assign br_taken    = ((funct3 == 3'b000) && aluZero) || ((funct3 == 3'b001) && !aluZero);

   assign req_s   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign wait_s  = req_s && !memReady;
   assign tmo_hit = wait_s && (tmo_q == TMO_LAST);

   // State register, memory timeout counter and writeback-source flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         tmo_q    <= '0;
         wb_mem_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         wb_mem_q <= wb_mem_d;
      end
   end

   // Next-state logic; a handshake in the final wait cycle beats the timeout.
   always_comb begin
      state_d  = state_q;
      tmo_d    = wait_s ? (tmo_q + 8'd1) : 8'd0;
      wb_mem_d = wb_mem_q;
      case (state_q)
         S_FETCH: begin
            if (memReady)     state_d = S_DECODE;
            else if (tmo_hit) state_d = S_FAULT;
         end
         S_DECODE: state_d = op_legal ? S_EXEC : S_FAULT;
         S_EXEC: begin
            wb_mem_d = is_lw;
            if (is_rtype || is_addi) state_d = S_WB;
            else if (is_lw)          state_d = S_MEMRD;
            else if (is_sw)          state_d = S_MEMWR;
            else if (is_branch)      state_d = S_FETCH;
            else                     state_d = S_FAULT;
         end
         S_MEMRD: begin
            if (memReady)     state_d = S_WB;
            else if (tmo_hit) state_d = S_FAULT;
         end
         S_MEMWR: begin
            if (memReady)     state_d = S_FETCH;
            else if (tmo_hit) state_d = S_FAULT;
         end
         S_WB:    state_d = S_FETCH;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
   end

   // Datapath controls decoded from state; everything is held low during reset.
   always_comb begin
      memReq   = 1'b0;
      memWrite = 1'b0;
      iOrD     = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      pcSrc    = 1'b0;
      regWrite = 1'b0;
      memToReg = 1'b0;
      aluSrcA  = 1'b0;
      aluSrcB  = 2'b00;
      aluOp    = 2'b00;
      fault    = 1'b0;
      retire   = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               memReq  = 1'b1;
               aluSrcB = 2'b01;
               irWrite = memReady;
               pcWrite = memReady;
            end
            S_DECODE: aluSrcB = 2'b10;
            S_EXEC: begin
               aluSrcA = 1'b1;
               if (is_rtype) begin
                  aluOp = 2'b10;
               end else if (is_addi) begin
                  aluSrcB = 2'b10;
                  aluOp   = 2'b10;
               end else if (is_lw || is_sw) begin
                  aluSrcB = 2'b10;
               end else if (is_branch) begin
                  aluOp   = 2'b01;
                  retire  = 1'b1;
                  pcWrite = br_taken;
                  pcSrc   = br_taken;
               end
            end
            S_MEMRD: begin
               memReq = 1'b1;
               iOrD   = 1'b1;
            end
            S_MEMWR: begin
               memReq   = 1'b1;
               memWrite = 1'b1;
               iOrD     = 1'b1;
               retire   = memReady;
            end
            S_WB: begin
               regWrite = 1'b1;
               memToReg = wb_mem_q;
               retire   = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: fault = 1'b1;
         endcase
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cyc_q, ret_q;

   // Free-running cycle and retired-instruction counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
         if (retire) ret_q <= ret_q + 32'd1;
      end
   end

   assign cycleCount  = rst_n ? cyc_q : 32'd0;
   assign instRetired = rst_n ? ret_q : 32'd0;
`else
   assign cycleCount  = 32'd0;
   assign instRetired = 32'd0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the SimpleCPU datapath. It sequences instruction fetch, decode, execute, memory access and writeback over the shared memory port, register file, ALU and immediate generator. It decodes the supported opcodes: R-type, addi, lw, sw, beq and bne. It produces per-cycle datapath selects and enables, and runs a request/ready handshake with memory. It sits between the instruction register and the datapath muxes/enables.

## Interface
- MEM_TIMEOUT, default 15: max cycles memReq may stay high without memReady before fault; range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- opcode  input  7  instruction[6:0] from the instruction register.
- funct3  input  3  instruction[14:12].
- funct7b5  input  1  instruction[30].
- aluZero  input  1  ALU zero flag.
- memReady  input  1  memory completes the current access.
- memReq  output  1  memory access request.
- memWrite  output  1  access is a store; valid only with memReq.
- iOrD  output  1  memory address source: 0 = PC, 1 = ALUOut.
- irWrite  output  1  load instruction register.
- pcWrite  output  1  load PC.
- pcSrc  output  1  PC source: 0 = ALU result, 1 = ALUOut register.
- regWrite  output  1  register file write enable.
- memToReg  output  1  writeback source: 0 = ALUOut, 1 = memory data register.
- aluSrcA  output  1  ALU A input: 0 = PC, 1 = rs1.
- aluSrcB  output  2  ALU B input: 00 = rs2, 01 = constant 4, 10 = immediate.
- aluOp  output  2  00 = add, 01 = sub, 10 = decode funct3/funct7b5.
- fault  output  1  sticky fault (illegal opcode or memory timeout).
- retire  output  1  one-cycle pulse per completed instruction.
- cycleCount  output  32  performance counter; see Configuration.
- instRetired  output  32  performance counter; see Configuration.

## Operation
- States: FETCH, DECODE, EXEC, MEMRD, MEMWR, WB, FAULT. Outputs are Moore, decoded from state.
- **FETCH**
  - Outputs: memReq=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00.
  - Holds until memReady=1.
  - In the memReady cycle it asserts irWrite=1, pcWrite=1, pcSrc=0 (PC+4), then goes to DECODE.
- **DECODE**
  - Outputs: aluSrcA=0, aluSrcB=10, aluOp=00. This computes the branch target into ALUOut.
  - Next state by opcode:
    - 0110011, 0010011, 0000011, 0100011 → EXEC.
    - 1100011 with funct3 ∈ {000, 001} → EXEC.
    - Anything else → FAULT.
- **EXEC**
  - R-type: aluSrcA=1, aluSrcB=00, aluOp=10 → WB.
  - addi: aluSrcB=10, aluOp=10 → WB.
  - lw: aluSrcB=10, aluOp=00 → MEMRD.
  - sw: aluSrcB=10, aluOp=00 → MEMWR.
  - Branch: aluSrcA=1, aluSrcB=00, aluOp=01.
    - Taken when (funct3=000 and aluZero) or (funct3=001 and !aluZero).
    - Taken: pcWrite=1, pcSrc=1.
    - Branch retires here and goes to FETCH.
- **MEMRD**: memReq=1, iOrD=1. On memReady → WB.
- **MEMWR**: memReq=1, memWrite=1, iOrD=1. On memReady, retire and go to FETCH.
- **WB**: regWrite=1; memToReg=1 only for lw. Retire and go to FETCH.
- **FAULT**: absorbing state; all enables 0, fault=1. Only reset exits it.
- Opcode, funct3 and funct7b5 are sampled only in DECODE and EXEC. The instruction register is stable outside FETCH.

## Timing
- Reset (rst_n=0 at a clock edge):
  - Next state is FETCH; timeout counter and perf counters clear to 0.
  - While rst_n=0, every output is forced 0.
- Reset mid-operation aborts the instruction. The first cycle after release is FETCH with memReq=1.
- Handshake:
  - memReq stays high until memReady is sampled high; the access completes in that same cycle.
  - memReady while memReq=0 is ignored.
- Latency with zero-wait memory: branch 3 cycles; R-type, addi and sw 4; lw 5. Each memory wait cycle adds 1.
- Timeout counter:
  - Increments each cycle memReq=1 and memReady=0.
  - Clears on any handshake completion.
  - Reaching MEM_TIMEOUT → FAULT on the next edge. If memReady arrives in that same cycle, the handshake wins.
- retire is high in exactly one cycle per instruction: the WB cycle, the MEMWR completion cycle, or the branch EXEC cycle.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - cycleCount increments every cycle out of reset, including FAULT.
  - instRetired increments on each retire.
  - Both are 32-bit and wrap 0xFFFFFFFF → 0.
- Not defined: both ports are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- addi x1,x0,5 (0x00500093), zero-wait memory → states FETCH, DECODE, EXEC, WB; regWrite=1 only in cycle 4; retire pulses in cycle 4.
- lw with memReady delayed 3 cycles in MEMRD → memReq held 4 cycles with iOrD=1; WB has memToReg=1; total 8 cycles.
- beq with aluZero=1 → pcWrite=1 and pcSrc=1 in EXEC. Same with aluZero=0 → pcWrite=0. bne mirrored. Each takes 3 cycles.
- Opcode 0x7F → FAULT after DECODE; fault=1 held for 100 cycles; rst_n=0 for 1 cycle → FETCH, fault=0.
- memReady never asserted in FETCH with MEM_TIMEOUT=15 → FAULT entered 15 cycles after memReq rises. memReady arriving on the 15th wait cycle completes the fetch normally instead.
- With CTRL_PERF_CNT_EN defined: 10 back-to-back addi → instRetired=10 and cycleCount=40. Rebuilt without the macro, both ports read 0.
